// File: rtl/trx_sequencer_pkg.sv
// Shared definitions for the T/R sequencer: state encoding, default settle
// times and small state-classification helpers.
package trx_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_RX      = 3'd0,
      ST_MUTE    = 3'd1,
      ST_KEY     = 3'd2,
      ST_RAMP_UP = 3'd3,
      ST_TX      = 3'd4,
      ST_RAMP_DN = 3'd5,
      ST_UNKEY   = 3'd6,
      ST_RELEASE = 3'd7
   } seq_state_t;

   localparam int unsigned DEF_MUTE_DLY  = 100;
   localparam int unsigned DEF_RELAY_DLY = 500;
   localparam int unsigned DEF_RAMP_STEP = 4;

   // The relay stays pulled in from KEY until the end of UNKEY.
   function automatic logic relay_on(input seq_state_t s);
      return s inside {ST_KEY, ST_RAMP_UP, ST_TX, ST_RAMP_DN, ST_UNKEY};
   endfunction

   function automatic logic drive_on(input seq_state_t s);
      return s inside {ST_RAMP_UP, ST_TX, ST_RAMP_DN};
   endfunction

endpackage

// File: rtl/trx_sequencer_sync2.sv
// Two-flop synchronizer bringing the raw CW key into the clock_100k domain.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/trx_sequencer.sv
// Transmit/receive sequencer: mutes the receiver, keys the relay, ramps the
// drive level up and down, and unwinds safely on fault or loss of PLL lock.
module trx_sequencer
   import trx_sequencer_pkg::*;
#(
   parameter int unsigned MUTE_DLY  = DEF_MUTE_DLY,
   parameter int unsigned RELAY_DLY = DEF_RELAY_DLY,
   parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
   input  logic       clock_100k,
   input  logic       nRES,
   input  logic       ptt_req,
   input  logic       CW,
   input  logic       lock,
   input  logic       fault,
   input  logic [7:0] tx_level,
   output logic       rx_mute,
   output logic       relay_tx,
   output logic       tx_enable,
   output logic [7:0] level_out,
   output logic [2:0] seq_state
);

   localparam int unsigned MAX_DLY = (MUTE_DLY > RELAY_DLY) ? MUTE_DLY : RELAY_DLY;
   localparam int unsigned CNT_W   = (MAX_DLY < 2) ? 1 : $clog2(MAX_DLY);
   localparam logic [CNT_W-1:0] MUTE_LAST  = CNT_W'(MUTE_DLY - 1);
   localparam logic [CNT_W-1:0] RELAY_LAST = CNT_W'(RELAY_DLY - 1);
   localparam logic [7:0]       STEP8      = 8'(RAMP_STEP);

   seq_state_t       state;
   seq_state_t       next_state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       next_level;
   logic [8:0]       up_sum;
   logic [7:0]       up_level;
   logic [7:0]       dn_level;
   logic             cw_sync;
   logic             tx_req;
   logic             abort;

   sync2 u_cw_sync (
      .clk   (clock_100k),
      .rst_n (nRES),
      .d     (CW),
      .q     (cw_sync)
   );

   assign tx_req = ptt_req | cw_sync;
   assign abort  = fault | ~lock;

   // Ramp arithmetic is done one bit wider so a step past 255 clamps instead of wrapping.
   assign up_sum   = {1'b0, level_out} + 9'(RAMP_STEP);
   assign up_level = (up_sum > {1'b0, tx_level}) ? tx_level : up_sum[7:0];
   assign dn_level = (level_out > STEP8) ? (level_out - STEP8) : 8'd0;

   always_comb begin
      next_state = state;
      next_level = level_out;
      unique case (state)
         ST_RX: begin
            if (tx_req && lock) next_state = ST_MUTE;
         end
         ST_MUTE: begin
            if (!lock)                 next_state = ST_RELEASE;
            else if (!tx_req)          next_state = ST_RX;
            else if (cnt == MUTE_LAST) next_state = ST_KEY;
         end
         ST_KEY: begin
            if (abort || !tx_req)       next_state = ST_UNKEY;
            else if (cnt == RELAY_LAST) next_state = ST_RAMP_UP;
         end
         ST_RAMP_UP: begin
            if (abort)                       next_state = ST_UNKEY;
            else if (!tx_req)                next_state = ST_RAMP_DN;
            else if (level_out == tx_level)  next_state = ST_TX;
            else                             next_level = up_level;
         end
         ST_TX: begin
            if (abort)        next_state = ST_UNKEY;
            else if (!tx_req) next_state = ST_RAMP_DN;
            else              next_level = tx_level;
         end
         ST_RAMP_DN: begin
            if (abort)                  next_state = ST_UNKEY;
            else if (tx_req)            next_state = ST_RAMP_UP;
            else if (level_out == 8'd0) next_state = ST_UNKEY;
            else                        next_level = dn_level;
         end
         ST_UNKEY: begin
            if (cnt == RELAY_LAST) next_state = ST_RELEASE;
         end
         ST_RELEASE: begin
            if (cnt == MUTE_LAST) next_state = ST_RX;
         end
         default: next_state = ST_RX;
      endcase
   end

   // Outputs are decoded from the state being entered so they switch on the same edge.
   always_ff @(posedge clock_100k or negedge nRES) begin
      if (!nRES) begin
         state     <= ST_RX;
         cnt       <= '0;
         rx_mute   <= 1'b0;
         relay_tx  <= 1'b0;
         tx_enable <= 1'b0;
         level_out <= 8'd0;
      end else begin
         state     <= next_state;
         cnt       <= (next_state != state) ? '0 : cnt + CNT_W'(1);
         rx_mute   <= (next_state != ST_RX);
         relay_tx  <= relay_on(next_state);
         tx_enable <= drive_on(next_state);
         level_out <= drive_on(next_state) ? next_level : 8'd0;
      end
   end

   assign seq_state = state;

endmodule

// File: tb/tb_trx_sequencer.sv
// Self-checking bench: directed timelines for the key sequences plus
// randomized traffic scored against a phase/countdown reference model.
module tb_trx_sequencer;

   localparam int MUTE_DLY  = 4;
   localparam int RELAY_DLY = 8;
   localparam int RAMP_STEP = 16;

   localparam int S_RX = 0, S_MUTE = 1, S_KEY = 2, S_RAMP_UP = 3;
   localparam int S_TX = 4, S_RAMP_DN = 5, S_UNKEY = 6, S_RELEASE = 7;

   typedef struct packed {
      logic       rx_mute;
      logic       relay_tx;
      logic       tx_enable;
      logic [7:0] level;
      logic [2:0] state;
   } obs_t;

   logic       clock_100k = 1'b0;
   logic       nRES       = 1'b0;
   logic       ptt_req    = 1'b0;
   logic       CW         = 1'b0;
   logic       lock       = 1'b0;
   logic       fault      = 1'b0;
   logic [7:0] tx_level   = 8'd0;
   logic       rx_mute;
   logic       relay_tx;
   logic       tx_enable;
   logic [7:0] level_out;
   logic [2:0] seq_state;

   int   n_checks = 0;
   int   n_fail   = 0;
   obs_t exp_q[$];
   obs_t rec[0:40];

   int m_phase = S_RX;
   int m_left  = 0;
   int m_lvl   = 0;
   bit m_s1    = 1'b0;
   bit m_s2    = 1'b0;

   trx_sequencer #(
      .MUTE_DLY  (MUTE_DLY),
      .RELAY_DLY (RELAY_DLY),
      .RAMP_STEP (RAMP_STEP)
   ) dut (
      .clock_100k (clock_100k),
      .nRES       (nRES),
      .ptt_req    (ptt_req),
      .CW         (CW),
      .lock       (lock),
      .fault      (fault),
      .tx_level   (tx_level),
      .rx_mute    (rx_mute),
      .relay_tx   (relay_tx),
      .tx_enable  (tx_enable),
      .level_out  (level_out),
      .seq_state  (seq_state)
   );

   always #5 clock_100k = ~clock_100k;

   function automatic obs_t cur();
      obs_t o;
      o.rx_mute   = rx_mute;
      o.relay_tx  = relay_tx;
      o.tx_enable = tx_enable;
      o.level     = level_out;
      o.state     = seq_state;
      return o;
   endfunction

   task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s @%0t: got mute=%0b relay=%0b txen=%0b lvl=%0d st=%0d, want mute=%0b relay=%0b txen=%0b lvl=%0d st=%0d",
                  name, $time, act.rx_mute, act.relay_tx, act.tx_enable, act.level, act.state,
                  exp.rx_mute, exp.relay_tx, exp.tx_enable, exp.level, exp.state);
      end
   endtask

   task automatic checkValue(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   // Reference model: each phase has a dwell time counted down from entry.
   function automatic int dwell(input int p);
      if (p == S_MUTE || p == S_RELEASE) return MUTE_DLY;
      if (p == S_KEY || p == S_UNKEY)    return RELAY_DLY;
      return 0;
   endfunction

   task automatic enter(input int p);
      m_phase = p;
      m_left  = dwell(p);
      if (p < S_RAMP_UP || p > S_RAMP_DN) m_lvl = 0;
   endtask

   task automatic tick(input int nxt);
      m_left--;
      if (m_left == 0) enter(nxt);
   endtask

   task automatic modelStep();
      bit treq, bad;
      int tgt;
      treq = ptt_req || m_s2;
      m_s2 = m_s1;
      m_s1 = CW;
      bad  = fault || !lock;
      tgt  = int'(tx_level);
      case (m_phase)
         S_RX:      if (treq && lock) enter(S_MUTE);
         S_MUTE:    if (!lock) enter(S_RELEASE); else if (!treq) enter(S_RX); else tick(S_KEY);
         S_KEY:     if (bad || !treq) enter(S_UNKEY); else tick(S_RAMP_UP);
         S_RAMP_UP: if (bad) enter(S_UNKEY); else if (!treq) enter(S_RAMP_DN);
                    else if (m_lvl == tgt) enter(S_TX);
                    else m_lvl = (m_lvl + RAMP_STEP < tgt) ? m_lvl + RAMP_STEP : tgt;
         S_TX:      if (bad) enter(S_UNKEY); else if (!treq) enter(S_RAMP_DN); else m_lvl = tgt;
         S_RAMP_DN: if (bad) enter(S_UNKEY); else if (treq) enter(S_RAMP_UP);
                    else if (m_lvl == 0) enter(S_UNKEY);
                    else m_lvl = (m_lvl > RAMP_STEP) ? m_lvl - RAMP_STEP : 0;
         S_UNKEY:   tick(S_RELEASE);
         default:   tick(S_RX);
      endcase
   endtask

   always @(posedge clock_100k) begin
      obs_t e;
      if (!nRES) begin
         m_phase = S_RX; m_left = 0; m_lvl = 0; m_s1 = 1'b0; m_s2 = 1'b0;
      end else begin
         modelStep();
      end
      e.rx_mute   = (m_phase != S_RX);
      e.relay_tx  = (m_phase >= S_KEY && m_phase <= S_UNKEY);
      e.tx_enable = (m_phase >= S_RAMP_UP && m_phase <= S_RAMP_DN);
      e.level     = 8'(m_lvl);
      e.state     = 3'(m_phase);
      exp_q.push_back(e);
   end

   always @(negedge clock_100k) begin
      obs_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (!nRES) e = '0;
         checkOutput("scoreboard", cur(), e);
      end
   end

   task automatic applyStimulus(input bit p, input bit c, input bit l, input bit f, input logic [7:0] lv);
      @(posedge clock_100k);
      #1;
      ptt_req  = p;
      CW       = c;
      lock     = l;
      fault    = f;
      tx_level = lv;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clock_100k);
   endtask

   task automatic capture(input int n);
      for (int i = 0; i <= n; i++) begin
         @(negedge clock_100k);
         rec[i] = cur();
      end
   endtask

   function automatic int firstHigh(input int sel, input int n);
      for (int i = 0; i <= n; i++) begin
         if (sel == 0 && rec[i].rx_mute)   return i;
         if (sel == 1 && rec[i].relay_tx)  return i;
         if (sel == 2 && rec[i].tx_enable) return i;
      end
      return -1;
   endfunction

   function automatic int countState(input int s, input int n);
      int c = 0;
      for (int i = 0; i <= n; i++) if (int'(rec[i].state) == s) c++;
      return c;
   endfunction

   initial begin
      int up_lv[7];
      int dn_lv[7];
      int len, idle;
      bit use_cw;
      logic [7:0] lv;
      up_lv = '{16, 32, 48, 64, 80, 96, 100};
      dn_lv = '{84, 68, 52, 36, 20, 4, 0};

      lock = 1'b1;
      tx_level = 8'd100;
      waitCycles(3);
      #1;
      checkOutput("reset_state", cur(), '0);
      nRES = 1'b1;
      waitCycles(3);

      // Full key-up from RX with ptt_req held.
      applyStimulus(1, 0, 1, 0, 100);
      capture(24);
      checkValue("keyup_rx_mute_cycle", firstHigh(0, 24), 1);
      checkValue("keyup_relay_cycle", firstHigh(1, 24), 5);
      checkValue("keyup_txen_cycle", firstHigh(2, 24), 13);
      for (int i = 0; i < 7; i++) checkValue("keyup_level", int'(rec[14 + i].level), up_lv[i]);
      checkValue("keyup_tx_state", int'(rec[21].state), S_TX);

      // Key-down from TX at level 100.
      applyStimulus(0, 0, 1, 0, 100);
      capture(24);
      checkValue("keydn_hold_level", int'(rec[1].level), 100);
      for (int i = 0; i < 7; i++) checkValue("keydn_level", int'(rec[2 + i].level), dn_lv[i]);
      checkValue("keydn_unkey_len", countState(S_UNKEY, 24), RELAY_DLY);
      checkValue("keydn_release_len", countState(S_RELEASE, 24), MUTE_DLY);
      checkValue("keydn_release_relay", int'(rec[17].relay_tx), 0);
      checkValue("keydn_back_rx", int'(rec[21].state), S_RX);

      // Two-cycle ptt pulse: mute only, relay never engages.
      applyStimulus(1, 0, 1, 0, 100);
      for (int i = 0; i <= 10; i++) begin
         @(negedge clock_100k);
         rec[i] = cur();
         if (i == 2) ptt_req = 1'b0;
      end
      checkValue("pulse_mute_state", int'(rec[1].state), S_MUTE);
      checkValue("pulse_back_rx", int'(rec[3].state), S_RX);
      checkValue("pulse_relay_never", firstHigh(1, 10), -1);

      // Fault during ramp-up at level 48.
      applyStimulus(1, 0, 1, 0, 100);
      for (int i = 0; i <= 30; i++) begin
         @(negedge clock_100k);
         rec[i] = cur();
         if (i == 16) fault = 1'b1;
         if (i == 17) fault = 1'b0;
      end
      checkValue("fault_pre_level", int'(rec[16].level), 48);
      checkValue("fault_level_zero", int'(rec[17].level), 0);
      checkValue("fault_txen_off", int'(rec[17].tx_enable), 0);
      checkValue("fault_unkey_state", int'(rec[17].state), S_UNKEY);
      checkValue("fault_unkey_len", countState(S_UNKEY, 30), RELAY_DLY);
      applyStimulus(0, 0, 1, 0, 100);
      waitCycles(40);

      // CW key alone: same sequence two synchronizer cycles later.
      applyStimulus(0, 1, 1, 0, 100);
      capture(26);
      checkValue("cw_rx_mute_cycle", firstHigh(0, 26), 3);
      checkValue("cw_relay_cycle", firstHigh(1, 26), 7);
      checkValue("cw_txen_cycle", firstHigh(2, 26), 15);
      checkValue("cw_first_level", int'(rec[16].level), 16);
      checkValue("cw_top_level", int'(rec[22].level), 100);
      checkValue("cw_tx_state", int'(rec[23].state), S_TX);
      applyStimulus(0, 0, 1, 0, 100);
      waitCycles(40);

      // Reset in TX clears outputs at once, then sequencing restarts.
      applyStimulus(1, 0, 1, 0, 100);
      waitCycles(25);
      checkValue("pre_reset_tx", int'(seq_state), S_TX);
      @(posedge clock_100k);
      #1 nRES = 1'b0;
      #1 checkOutput("async_reset", cur(), '0);
      @(posedge clock_100k);
      #1 nRES = 1'b1;
      capture(8);
      checkValue("restart_mute_state", int'(rec[1].state), S_MUTE);
      checkValue("restart_relay_cycle", firstHigh(1, 8), 5);
      applyStimulus(0, 0, 1, 0, 100);
      waitCycles(40);

      // Randomized bursts scored by the reference model.
      for (int b = 0; b < 30; b++) begin
         len    = $urandom_range(3, 45);
         use_cw = ($urandom_range(0, 3) == 0);
         for (int c = 0; c < len; c++) begin
            lv = tx_level;
            if ($urandom_range(0, 9) == 0)
               lv = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            applyStimulus(!use_cw, use_cw, $urandom_range(0, 29) != 0, $urandom_range(0, 49) == 0, lv);
         end
         idle = $urandom_range(1, 30);
         for (int c = 0; c < idle; c++)
            applyStimulus(0, 0, $urandom_range(0, 29) != 0, 0, tx_level);
      end

      applyStimulus(0, 0, 1, 0, 8'd0);
      waitCycles(40);
      @(negedge clock_100k);
      @(negedge clock_100k);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
